// File: rtl/gcd_pkg.sv
// Shared types, defaults and helpers for the GCD request/engine interface.
package gcd_pkg;

  localparam int unsigned GCD_WIDTH     = 32;
  localparam int unsigned GCD_TIMEOUT   = 256;
  // Widest operand the trivial-pair check handles; narrower operands are zero-extended.
  localparam int unsigned GCD_MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } gcd_req_st_e;

  // Which operand is the answer for a pair that needs no engine.
  typedef enum logic [1:0] {
    TRIV_NONE,
    TRIV_A,
    TRIV_B
  } triv_sel_e;

  typedef struct packed {
    logic      trivial;
    triv_sel_e sel;
  } triv_t;

  // gcd(0,b)=b, gcd(a,0)=a, gcd(a,a)=a; anything else needs the engine.
  function automatic triv_t is_trivial(input logic [GCD_MAX_WIDTH-1:0] a,
                                       input logic [GCD_MAX_WIDTH-1:0] b);
    triv_t r;
    r.trivial = 1'b1;
    r.sel     = TRIV_A;
    if (a == '0) begin
      r.sel = TRIV_B;
    end else if (b == '0) begin
      r.sel = TRIV_A;
    end else if (a == b) begin
      r.sel = TRIV_A;
    end else begin
      r.trivial = 1'b0;
      r.sel     = TRIV_NONE;
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_inc,
  output logic [CW-1:0] o_cnt
);

  logic [CW-1:0] r_cnt;

  // Count increments, holding once saturated.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/gcd_req_master.sv
// Requesting side of the start/busy/done GCD engine interface, with local
// resolution of trivial pairs, a done watchdog and saturating status counters.
module gcd_req_master
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH   = GCD_WIDTH,
  parameter int unsigned TIMEOUT = GCD_TIMEOUT,
  parameter int unsigned CW      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             eng_start,
  output logic [WIDTH-1:0] eng_a,
  output logic [WIDTH-1:0] eng_b,
  input  logic             eng_busy,
  input  logic             eng_done,
  input  logic [WIDTH-1:0] eng_gcd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_err,
  output logic [CW-1:0]    cnt_ok,
  output logic [CW-1:0]    cnt_err
);

  localparam int unsigned TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  gcd_req_st_e      r_state, w_state_nxt;
  logic [TW-1:0]    r_timer, w_timer_nxt;
  logic             r_eng_start, w_eng_start_nxt;
  logic [WIDTH-1:0] r_eng_a, w_eng_a_nxt;
  logic [WIDTH-1:0] r_eng_b, w_eng_b_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic [WIDTH-1:0] r_out_gcd, w_out_gcd_nxt;
  logic             r_out_err, w_out_err_nxt;
  logic             w_ok_inc;
  logic             w_err_inc;
  triv_t            w_triv;

  assign w_triv = is_trivial(GCD_MAX_WIDTH'(in_a), GCD_MAX_WIDTH'(in_b));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    w_state_nxt     = r_state;
    w_timer_nxt     = r_timer;
    w_eng_start_nxt = 1'b0;
    w_eng_a_nxt     = r_eng_a;
    w_eng_b_nxt     = r_eng_b;
    w_out_valid_nxt = r_out_valid;
    w_out_gcd_nxt   = r_out_gcd;
    w_out_err_nxt   = r_out_err;
    w_ok_inc        = 1'b0;
    w_err_inc       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_eng_a_nxt = in_a;
          w_eng_b_nxt = in_b;
          if (w_triv.trivial) begin
            w_out_gcd_nxt   = (w_triv.sel == TRIV_B) ? in_b : in_a;
            w_out_err_nxt   = 1'b0;
            w_out_valid_nxt = 1'b1;
            w_ok_inc        = 1'b1;
            w_state_nxt     = S_HOLD;
          end else begin
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (!eng_busy) begin
          w_eng_start_nxt = 1'b1;
          w_timer_nxt     = '0;
          w_state_nxt     = S_WAIT;
        end
      end
      S_WAIT: begin
        w_timer_nxt = r_timer + TW'(1);
        // A done coinciding with the last timer cycle still counts as a result.
        if (eng_done) begin
          w_out_gcd_nxt   = eng_gcd;
          w_out_err_nxt   = 1'b0;
          w_out_valid_nxt = 1'b1;
          w_ok_inc        = 1'b1;
          w_state_nxt     = S_HOLD;
        end else if (r_timer == TMO_LAST) begin
          w_out_gcd_nxt   = '0;
          w_out_err_nxt   = 1'b1;
          w_out_valid_nxt = 1'b1;
          w_err_inc       = 1'b1;
          w_state_nxt     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output and timer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_timer     <= '0;
      r_eng_start <= 1'b0;
      r_eng_a     <= '0;
      r_eng_b     <= '0;
      r_out_valid <= 1'b0;
      r_out_gcd   <= '0;
      r_out_err   <= 1'b0;
    end else begin
      r_timer     <= w_timer_nxt;
      r_eng_start <= w_eng_start_nxt;
      r_eng_a     <= w_eng_a_nxt;
      r_eng_b     <= w_eng_b_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_gcd   <= w_out_gcd_nxt;
      r_out_err   <= w_out_err_nxt;
    end
  end

  sat_counter #(.CW(CW)) u_cnt_ok (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_ok_inc),
    .o_cnt (cnt_ok)
  );

  sat_counter #(.CW(CW)) u_cnt_err (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_err_inc),
    .o_cnt (cnt_err)
  );

  assign in_ready  = (r_state == S_IDLE);
  assign eng_start = r_eng_start;
  assign eng_a     = r_eng_a;
  assign eng_b     = r_eng_b;
  assign out_valid = r_out_valid;
  assign out_gcd   = r_out_gcd;
  assign out_err   = r_out_err;

endmodule

// File: doc/gcd_req_master.md
Name: gcd_req_master

Overview:
- Initiator for the team's start/busy/done GCD engine interface, i.e. the requesting side of that protocol.
- Accepts operand pairs on a valid/ready stream and issues each pair to the engine as a one-cycle start pulse.
- Waits for done with a timeout watchdog and returns the result on a valid/ready output stream.
- Trivial pairs are resolved locally without using the engine; saturating status counters are kept for software.

Parameters:
- WIDTH, 32, operand/result width; must match the engine.
- TIMEOUT, 256, max cycles in WAIT before the request is aborted; must be >= 2.
- CW, 16, width of the status counters.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; synchronous, active-low
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept a pair
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- eng_start  output  1  one-cycle request pulse to engine
- eng_a  output  WIDTH  operand A to engine
- eng_b  output  WIDTH  operand B to engine
- eng_busy  input  1  engine busy
- eng_done  input  1  engine one-cycle done pulse
- eng_gcd  input  WIDTH  engine result, valid with eng_done
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_gcd  output  WIDTH  result (0 on error)
- out_err  output  1  result is a timeout abort
- cnt_ok  output  CW  completed requests, saturating
- cnt_err  output  CW  timed-out requests, saturating

Behaviour:
- All outputs are registered except in_ready, which equals (state==IDLE).
- Reset (rst_n low at a clk edge, any state, including mid-WAIT):
  - state=IDLE.
  - eng_start, out_valid, out_err = 0.
  - eng_a, eng_b, out_gcd, cnt_ok, cnt_err = 0.
  - Timer = 0.
  - An engine done arriving after reset is ignored.
- States: IDLE, ISSUE, WAIT, HOLD.
- IDLE, on in_valid && in_ready: capture in_a/in_b into eng_a/eng_b, then:
  - a==0: out_gcd=b, go to HOLD.
  - else b==0: out_gcd=a, go to HOLD.
  - else a==b: out_gcd=a, go to HOLD.
  - else: go to ISSUE.
  - Local results set out_err=0 and increment cnt_ok.
  - Local path latency: accept edge to out_valid high = 1 cycle.
- ISSUE:
  - If eng_busy==0: eng_start=1 for exactly one cycle, clear timer, go to WAIT.
  - If eng_busy==1: stay in ISSUE with eng_start=0.
  - eng_a/eng_b are held stable from capture until HOLD is exited.
- WAIT: timer increments every cycle.
  - eng_done: out_gcd=eng_gcd, out_err=0, cnt_ok++, go to HOLD.
  - Else if timer==TIMEOUT-1: out_gcd=0, out_err=1, cnt_err++, go to HOLD.
  - eng_done in the same cycle as the timeout: done wins.
- HOLD:
  - out_valid=1; out_gcd/out_err stable until the handshake.
  - On out_ready: out_valid=0 next cycle, go to IDLE. in_ready is high in that IDLE cycle, not in the handshake cycle.
- eng_done seen in IDLE, ISSUE or HOLD (stray or late after timeout) is ignored; no state change.
- Only one request is outstanding; no reordering.
- Counters saturate at all-ones and never wrap.
- Engine path latency: ISSUE cycle + engine cycles + 1 capture cycle.

Decomposition:
- Shared package gcd_pkg:
  - State enum gcd_req_st_e {S_IDLE, S_ISSUE, S_WAIT, S_HOLD}.
  - Function is_trivial(a,b) returning a trivial flag and its result.
  - Default constants GCD_WIDTH=32, GCD_TIMEOUT=256.
- One natural sub-module: sat_counter (width CW, inc input, saturating). Instantiate it twice.
- The timer stays inline.

Test Plan:
- Engine model with 10-cycle latency; send (48,18) -> one eng_start pulse with eng_a=48, eng_b=18; out_gcd=6, out_err=0; cnt_ok=1.
- Send (0,7), then (9,0), then (5,5) -> no eng_start; out_gcd 7, 9, 5, each valid 1 cycle after accept; cnt_ok=3.
- Engine never asserts done, TIMEOUT=16, send (12,8) -> out_valid with out_gcd=0, out_err=1 exactly 16 cycles after eng_start; cnt_err=1. A stray done afterwards is ignored.
- eng_busy forced high 5 cycles at issue, send (35,21) -> eng_start delayed until busy low; result 7.
- out_ready low 6 cycles after result (270,192)=6 -> out_valid and out_gcd stable, in_ready=0 throughout; accepted on out_ready.
- rst_n low for 1 cycle mid-WAIT -> all outputs zero, IDLE next cycle; the subsequent engine done is ignored; next request (14,21)=7 completes normally.
